score_tracker: RTL and testbench
================================

// Module: score_tracker
// PURPOSE
//  Downstream of the game control FSM. Consumes its one-cycle add_score pulse and
//  score_multiplier (lines cleared this piece) and keeps the running BCD score,
//  total cleared lines, level and high score for the display/HUD logic.
//  Digit-serial BCD accumulation: one digit per cycle, repeated (level+1) times.
// PARAMETERS
//  DIGITS          6   BCD digits in score and high score
//  LINES_PER_LEVEL 10  lines per level-up; must be >= 4
//  MAX_LEVEL       15  level saturation value; level is 4 bits
// PORTS
//  clock            in   1         system clock; all state updates on posedge
//  reset            in   1         synchronous, active-high; clears everything
//  add_score        in   1         1-cycle request from control FSM
//  score_multiplier in   3         lines cleared by this piece (0..4; >4 clamps to 4)
//  game_over        in   1         level-sensitive; while high, add_score is ignored
//  new_game         in   1         1-cycle pulse: clear score/lines/level, keep high score
//  score_bcd        out  4*DIGITS  current score, digit 0 = LSD
//  high_score_bcd   out  4*DIGITS  best score since reset
//  lines_total      out  10        total lines cleared, saturates at 1023
//  level            out  4         current level, 0..MAX_LEVEL
//  busy             out  1         high while an update is in progress
//  overrun          out  1         1-cycle pulse: add_score dropped because busy
// BEHAVIOUR
//  Reset: all outputs, including high_score_bcd, are 0; FSM = IDLE.
//  Base points k=clamp(score_multiplier,4): 0->1, 1->40, 2->100, 3->300, 4->1200.
//  Points added = base * (level+1); level is latched at acceptance.
//  FSM states:
//   IDLE: add_score && !game_over && !new_game -> latch k, base, rep=level+1,
//         digit=0, carry=0; next cycle ADD; busy is 1 from the next cycle.
//   ADD:  per cycle, score[digit] <= BCD(score[digit]+base[digit]+carry); digit++.
//         base digits >= 4 are 0. At digit==DIGITS-1: carry out -> score = all 9s,
//         go LINES (stop repeating); else rep-1, and if rep hits 0 go LINES,
//         else digit=0, carry=0, stay in ADD.
//   LINES: lines_total += k (saturating); lines_in_level += k; when
//          >= LINES_PER_LEVEL: subtract LINES_PER_LEVEL and level++ (hold at MAX_LEVEL).
//          At most one level-up per event. -> HIGH.
//   HIGH: if score_bcd > high_score_bcd (unsigned compare of packed BCD),
//         copy score_bcd to high_score_bcd. -> IDLE.
//  Latency: busy is high for exactly (L+1)*DIGITS+2 cycles without saturation.
//  Saturation: fewer cycles. score_bcd is stable and final when busy falls.
//  Intermediate score_bcd values while busy are not valid for display.
//  add_score while busy -> ignored, overrun pulses the next cycle, state unchanged.
//  new_game in any state: next cycle score=0, lines_total=0, level=0,
//  lines_in_level=0, FSM=IDLE, busy=0. A job in progress is aborted.
//  new_game beats a simultaneous add_score; the add is dropped with no overrun.
//  reset has priority over new_game.
//  game_over does not abort a job already in progress.
//  Every BCD digit stays in 0..9 at all times.
// TESTING
//  T1 level 0, mult=1 pulse -> busy 8 cycles; score=000040, lines=1, high=000040
//  T2 preset level 2 via 20 single lines; mult=4 -> score +3600; busy 20 cycles
//  T3 mult 3,3,3,1 at level 0 -> lines_total=10, level 1 after 4th; remainder 0
//  T4 mult=7 -> treated as 4 (+1200*(L+1)); mult=0 -> +1*(L+1); lines +0
//  T5 add_score during busy -> overrun 1 cycle, score reflects one add only
//  T6 repeat tetrises to top: score holds 999999; new_game mid-ADD -> score 0,
//     busy 0 next cycle; high_score_bcd keeps its prior max

Source files
------------

// File: rtl/score_tracker.sv
// Score tracker: digit-serial BCD score accumulation, line/level bookkeeping
// and high-score capture, driven by one-cycle add_score requests.
module score_tracker #(
    parameter int unsigned DIGITS          = 6,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  add_score,
    input  logic [2:0]            score_multiplier,
    input  logic                  game_over,
    input  logic                  new_game,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_score_bcd,
    output logic [9:0]            lines_total,
    output logic [3:0]            level,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned LW = $clog2(LINES_PER_LEVEL + 4);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADD   = 2'd1;
    localparam logic [1:0] S_LINES = 2'd2;
    localparam logic [1:0] S_HIGH  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [2:0]    k;
    logic [15:0]   base;
    logic [4:0]    rep;
    logic [DW-1:0] digit;
    logic          carry;
    logic [LW-1:0] lines_in_level;

    logic          accept;
    logic          drop;
    logic [2:0]    k_clamped;
    logic [15:0]   base_lookup;
    logic [3:0]    cur_digit;
    logic [3:0]    base_digit;
    logic [4:0]    raw_sum;
    logic          carry_out;
    logic [3:0]    sum_digit;
    logic          last_digit;
    logic [10:0]   lines_sum;
    logic [LW-1:0] lil_sum;

    // Clamp the multiplier and look up the packed-BCD base points.
    always_comb begin
        k_clamped   = (score_multiplier > 3'd4) ? 3'd4 : score_multiplier;
        base_lookup = 16'h0001;
        case (k_clamped)
            3'd1:    base_lookup = 16'h0040;
            3'd2:    base_lookup = 16'h0100;
            3'd3:    base_lookup = 16'h0300;
            3'd4:    base_lookup = 16'h1200;
            default: base_lookup = 16'h0001;
        endcase
    end

    // One BCD digit add per cycle; base digits at position 4 and above are zero.
    always_comb begin
        cur_digit  = 4'd0;
        base_digit = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digit == DW'(i)) cur_digit = score_bcd[i*4 +: 4];
        end
        for (int i = 0; i < 4; i++) begin
            if (digit == DW'(i)) base_digit = base[i*4 +: 4];
        end
        raw_sum    = 5'(cur_digit) + 5'(base_digit) + 5'(carry);
        carry_out  = raw_sum > 5'd9;
        sum_digit  = carry_out ? 4'(raw_sum - 5'd10) : raw_sum[3:0];
        last_digit = (digit == DW'(DIGITS - 1));
        lines_sum  = 11'(lines_total) + 11'(k);
        lil_sum    = lines_in_level + LW'(k);
    end

    // Next-state logic; new_game forces IDLE from any state.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = add_score && !new_game && (state != S_IDLE);
        if (new_game) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (add_score && !game_over) begin
                        accept     = 1'b1;
                        state_next = S_ADD;
                    end
                end
                S_ADD: begin
                    if (last_digit && (carry_out || rep == 5'd1)) state_next = S_LINES;
                end
                S_LINES: state_next = S_HIGH;
                S_HIGH:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Datapath: score digits, lines, level, high score and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            score_bcd      <= '0;
            high_score_bcd <= '0;
            lines_total    <= '0;
            level          <= '0;
            lines_in_level <= '0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            k              <= '0;
            base           <= '0;
            rep            <= '0;
            digit          <= '0;
            carry          <= 1'b0;
        end else if (new_game) begin
            score_bcd      <= '0;
            lines_total    <= '0;
            level          <= '0;
            lines_in_level <= '0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            digit          <= '0;
            carry          <= 1'b0;
        end else begin
            overrun <= drop;
            busy    <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        k     <= k_clamped;
                        base  <= base_lookup;
                        rep   <= 5'(level) + 5'd1;
                        digit <= '0;
                        carry <= 1'b0;
                    end
                end
                S_ADD: begin
                    for (int i = 0; i < int'(DIGITS); i++) begin
                        if (digit == DW'(i)) score_bcd[i*4 +: 4] <= sum_digit;
                    end
                    if (last_digit) begin
                        if (carry_out) begin
                            score_bcd <= {DIGITS{4'h9}};
                        end else begin
                            rep   <= rep - 5'd1;
                            digit <= '0;
                            carry <= 1'b0;
                        end
                    end else begin
                        digit <= digit + DW'(1);
                        carry <= carry_out;
                    end
                end
                S_LINES: begin
                    lines_total <= (lines_sum > 11'd1023) ? 10'd1023 : lines_sum[9:0];
                    if (lil_sum >= LW'(LINES_PER_LEVEL)) begin
                        lines_in_level <= lil_sum - LW'(LINES_PER_LEVEL);
                        if (level < 4'(MAX_LEVEL)) level <= level + 4'd1;
                    end else begin
                        lines_in_level <= lil_sum;
                    end
                end
                S_HIGH: begin
                    if (score_bcd > high_score_bcd) high_score_bcd <= score_bcd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: integer reference model, expected
// results queued at issue, monitor checks when busy falls.
module tb_score_tracker;

    localparam int unsigned DIGITS = 6;
    localparam int MAXS = 999999;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        add_score = 1'b0;
    logic [2:0]  score_multiplier = 3'd0;
    logic        game_over = 1'b0;
    logic        new_game = 1'b0;
    logic [23:0] score_bcd;
    logic [23:0] high_score_bcd;
    logic [9:0]  lines_total;
    logic [3:0]  level;
    logic        busy;
    logic        overrun;

    score_tracker #(.DIGITS(6), .LINES_PER_LEVEL(10), .MAX_LEVEL(15)) dut (
        .clock(clock), .reset(reset), .add_score(add_score),
        .score_multiplier(score_multiplier), .game_over(game_over),
        .new_game(new_game), .score_bcd(score_bcd), .high_score_bcd(high_score_bcd),
        .lines_total(lines_total), .level(level), .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int score;
        int high;
        int lines;
        int lvl;
        int cycles;   // -1: aborted job, duration not checked
    } exp_t;

    exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    int m_score = 0, m_high = 0, m_lines = 0, m_level = 0, m_lil = 0;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model for one accepted event; pushes the expected outcome.
    task automatic model_add(input int mult);
        int kk, base, reps, s, cyc;
        int pts[5] = '{1, 40, 100, 300, 1200};
        exp_t e;
        kk   = (mult > 4) ? 4 : mult;
        base = pts[kk];
        reps = m_level + 1;
        s    = m_score;
        cyc  = reps * int'(DIGITS) + 2;
        for (int r = 1; r <= reps; r++) begin
            s += base;
            if (s > MAXS) begin
                s   = MAXS;
                cyc = r * int'(DIGITS) + 2;
                break;
            end
        end
        m_score = s;
        m_lines = (m_lines + kk > 1023) ? 1023 : m_lines + kk;
        m_lil  += kk;
        if (m_lil >= 10) begin
            m_lil -= 10;
            if (m_level < 15) m_level++;
        end
        if (m_score > m_high) m_high = m_score;
        e.score = m_score; e.high = m_high; e.lines = m_lines;
        e.lvl = m_level; e.cycles = cyc;
        exp_q.push_back(e);
    endtask

    task automatic pulse_raw(input int mult);
        @(posedge clock); #1;
        add_score = 1'b1;
        score_multiplier = 3'(mult);
        @(posedge clock); #1;
        add_score = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busy) return;
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic issue(input int mult);
        model_add(mult);
        pulse_raw(mult);
        wait_idle();
    endtask

    task automatic abort_mid_job(input int mult);
        exp_t e;
        pulse_raw(mult);
        @(negedge clock);
        @(negedge clock);
        check("abort_busy_before", longint'(busy), 1);
        m_score = 0; m_lines = 0; m_level = 0; m_lil = 0;
        e.score = 0; e.high = m_high; e.lines = 0; e.lvl = 0; e.cycles = -1;
        exp_q.push_back(e);
        @(posedge clock); #1;
        new_game = 1'b1;
        @(posedge clock); #1;
        new_game = 1'b0;
        @(negedge clock);
        check("abort_busy", longint'(busy), 0);
        check("abort_score", longint'(score_bcd), 0);
        check("abort_high", longint'(high_score_bcd), longint'(to_bcd(m_high)));
    endtask

    // Monitor: measures busy length and checks results when busy falls.
    int  busy_cnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_job", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("score", longint'(score_bcd), longint'(to_bcd(e.score)));
                check("high", longint'(high_score_bcd), longint'(to_bcd(e.high)));
                check("lines", longint'(lines_total), longint'(e.lines));
                check("level", longint'(level), longint'(e.lvl));
                if (e.cycles >= 0) check("busy_cycles", longint'(busy_cnt), longint'(e.cycles));
            end
            busy_cnt = 0;
        end
        prev_busy = busy;
    end

    initial begin
        int m;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_score", longint'(score_bcd), 0);
        check("rst_high", longint'(high_score_bcd), 0);
        check("rst_lines", longint'(lines_total), 0);
        check("rst_level", longint'(level), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_overrun", longint'(overrun), 0);
        reset = 1'b0;

        // Single line at level 0: +40, 8 busy cycles.
        issue(1);
        // Three triples and a single: 10 lines, level-up on the last one.
        issue(3); issue(3); issue(3); issue(1);
        // Out-of-range multiplier clamps to 4; zero lines scores base 1.
        issue(7);
        issue(0);

        // Second request while busy is dropped and flagged for one cycle.
        model_add(2);
        pulse_raw(2);
        @(negedge clock);
        pulse_raw(4);
        @(negedge clock);
        check("overrun_pulse", longint'(overrun), 1);
        @(negedge clock);
        check("overrun_clear", longint'(overrun), 0);
        wait_idle();

        // Randomized events, some blocked by game_over.
        for (int i = 0; i < 40; i++) begin
            m = int'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) begin
                game_over = 1'b1;
                pulse_raw(m);
                @(negedge clock);
                check("gameover_busy", longint'(busy), 0);
                check("gameover_score", longint'(score_bcd), longint'(to_bcd(m_score)));
                game_over = 1'b0;
            end else begin
                issue(m);
            end
        end

        // Tetrises until the score saturates.
        for (int i = 0; i < 300 && m_score < MAXS; i++) issue(4);
        issue(4);
        check("sat_score", longint'(score_bcd), longint'(to_bcd(MAXS)));

        // Abort mid-ADD keeps the high score.
        abort_mid_job(4);

        // Level 2 via 20 singles, then a tetris: +3600 over 20 busy cycles.
        for (int i = 0; i < 20; i++) issue(1);
        check("lvl2", longint'(level), 2);
        issue(4);
        check("after_abort_high", longint'(high_score_bcd), longint'(to_bcd(MAXS)));

        repeat (3) @(negedge clock);
        check("queue_drained", longint'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
